// File: rtl/spi_xfer_buffer.sv
// Byte-stream buffer between a host and an SPI master: TX/RX FIFOs plus a
// sequencer that keeps exactly one byte outstanding at the master.

module spi_xfer_buffer_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q;
  logic [AW-1:0]         rptr_q;
  logic [LW-1:0]         level_q;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rptr_q];
  assign level   = level_q;

  // Flush clears only the bookkeeping; stale storage is unreachable afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (do_pop && !do_push) level_q <= level_q - 1'b1;
    end
  end

endmodule

module spi_xfer_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  flush,
  output logic [LW-1:0]         tx_level,
  output logic [LW-1:0]         rx_level,
  output logic                  busy,
  output logic [15:0]           xfer_count,
  output logic [DATA_WIDTH-1:0] m_tx_data,
  output logic                  m_tx_valid,
  input  logic                  m_tx_ready,
  input  logic [DATA_WIDTH-1:0] m_rx_data,
  input  logic                  m_rx_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_e;

  state_e        state_q;
  logic          m_tx_valid_q;
  logic          busy_q;
  logic          discard_q;
  logic [15:0]   xfer_count_q;

  logic          tx_full;
  logic          tx_empty;
  logic          rx_full;
  logic          rx_empty;
  logic          handshake;
  logic          rx_push;

  assign handshake = m_tx_valid_q && m_tx_ready;
  assign rx_push   = (state_q == CAPTURE) && !discard_q;

  spi_xfer_buffer_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (handshake),
    .head      (m_tx_data),
    .level     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  spi_xfer_buffer_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (rx_push),
    .push_data (m_rx_data),
    .pop       (rd_ready),
    .head      (rd_data),
    .level     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign wr_ready   = !tx_full;
  assign rd_valid   = !rx_empty;
  assign m_tx_valid = m_tx_valid_q;
  assign busy       = busy_q;
  assign xfer_count = xfer_count_q;

  // RX space is reserved on entry to ISSUE; the host can only drain, so the
  // slot is still free when CAPTURE pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      m_tx_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      discard_q    <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!flush && !tx_empty && !rx_full) begin
            state_q      <= ISSUE;
            m_tx_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ISSUE: begin
          if (m_tx_ready) begin
            state_q      <= WAIT;
            m_tx_valid_q <= 1'b0;
            if (flush) discard_q <= 1'b1;
          end else if (flush) begin
            state_q      <= IDLE;
            m_tx_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        WAIT: begin
          if (flush)      discard_q <= 1'b1;
          if (m_rx_valid) state_q   <= CAPTURE;
        end
        CAPTURE: begin
          // The byte was sent either way, so it is counted even when discarded.
          xfer_count_q <= xfer_count_q + 16'd1;
          discard_q    <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q      <= IDLE;
          m_tx_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          discard_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_buffer.sv
// Randomized bench for spi_xfer_buffer: queue-based reference model plus a
// small SPI master model that returns the inverted transmit byte.

module tb_spi_xfer_buffer;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          flush;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic          busy;
  logic [15:0]   xfer_count;
  logic [DW-1:0] m_tx_data;
  logic          m_tx_valid;
  logic          m_tx_ready;
  logic [DW-1:0] m_rx_data;
  logic          m_rx_valid;

  always #5 clk = ~clk;

  spi_xfer_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .flush      (flush),
    .tx_level   (tx_level),
    .rx_level   (rx_level),
    .busy       (busy),
    .xfer_count (xfer_count),
    .m_tx_data  (m_tx_data),
    .m_tx_valid (m_tx_valid),
    .m_tx_ready (m_tx_ready),
    .m_rx_data  (m_rx_data),
    .m_rx_valid (m_rx_valid)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queues and the transfer phase (0 idle, 1 offering
  // a byte, 2 awaiting the strobe, 3 storing the returned byte).
  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  int            ph;
  bit            disc;
  logic [15:0]   cnt;

  // Master model state
  bit            mbusy;
  bit            mpost;
  int            mcnt;
  logic [DW-1:0] mbyte;
  int            rdy_pct;
  logic          s_vld;
  logic [DW-1:0] s_txd;

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    ph   = 0;
    disc = 0;
    cnt  = '0;
  endtask

  task automatic master_reset();
    mbusy      = 0;
    mpost      = 0;
    mcnt       = 0;
    m_rx_valid = 1'b0;
    m_rx_data  = '0;
    m_tx_ready = 1'b0;
    s_vld      = 1'b0;
    s_txd      = '0;
  endtask

  task automatic model_edge();
    int tn;
    int rn;
    tn = txq.size();
    rn = rxq.size();
    if (flush) begin
      txq.delete();
      rxq.delete();
    end else begin
      if (ph == 1 && m_tx_ready) void'(txq.pop_front());
      if (rd_ready && rn > 0) void'(rxq.pop_front());
      if (wr_valid && tn < DEPTH) txq.push_back(wr_data);
      if (ph == 3 && !disc) rxq.push_back(m_rx_data);
    end
    case (ph)
      0: if (!flush && tn != 0 && rn != DEPTH) ph = 1;
      1: begin
        if (m_tx_ready) begin
          ph = 2;
          if (flush) disc = 1;
        end else if (flush) ph = 0;
      end
      2: begin
        if (flush) disc = 1;
        if (m_rx_valid) ph = 3;
      end
      default: begin
        cnt  = cnt + 16'd1;
        disc = 0;
        ph   = 0;
      end
    endcase
    // master sees the DUT's offer as sampled before the edge
    if (s_vld && m_tx_ready) begin
      mbusy = 1;
      mbyte = s_txd;
      mcnt  = $urandom_range(1, 4);
    end
    if (m_rx_valid) mpost = 1;
  endtask

  task automatic drive_master();
    if (mpost) begin
      m_rx_valid = 1'b0;
      m_rx_data  = ~mbyte;
      mbusy      = 0;
      mpost      = 0;
    end else if (mbusy && mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        m_rx_valid = 1'b1;
        m_rx_data  = DW'($urandom);
      end
    end
    m_tx_ready = !mbusy && ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic check_all();
    chk("m_tx_valid", m_tx_valid, ph == 1);
    chk("busy", busy, ph != 0);
    chk("tx_level", tx_level, txq.size());
    chk("rx_level", rx_level, rxq.size());
    chk("wr_ready", wr_ready, txq.size() != DEPTH);
    chk("rd_valid", rd_valid, rxq.size() != 0);
    chk("xfer_count", xfer_count, cnt);
    if (rxq.size() != 0) chk("rd_data", rd_data, rxq[0]);
    if (txq.size() != 0) chk("m_tx_data", m_tx_data, txq[0]);
    s_vld = m_tx_valid;
    s_txd = m_tx_data;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
    drive_master();
  endtask

  task automatic write_byte(input logic [DW-1:0] b);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_in_flight(input int budget);
    int n;
    n = 0;
    while (!(busy && !m_tx_valid) && n < budget) begin
      step();
      n++;
    end
    chk("wait_in_flight_timeout", busy && !m_tx_valid, 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_m_tx_valid"}, m_tx_valid, 0);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_m_tx_data"}, m_tx_data, 0);
    chk({tag, "_tx_level"}, tx_level, 0);
    chk({tag, "_rx_level"}, rx_level, 0);
    chk({tag, "_xfer_count"}, xfer_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]   c0;
    logic [DW-1:0] nb;
    rst_n    = 1'b0;
    wr_data  = '0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    rdy_pct  = 100;
    model_reset();
    master_reset();
    #1;
    reset_checks("por");
    repeat (2) step();
    rst_n = 1'b1;

    // Single byte
    write_byte(8'hA5);
    chk("single_valid_lag", m_tx_valid, 0);
    step();
    chk("single_valid", m_tx_valid, 1);
    repeat (12) step();
    chk("single_rd", rd_data, 8'h5A);
    chk("single_cnt", xfer_count, 1);
    chk("single_busy", busy, 0);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;

    // Burst of 8 with the master stalled so the TX FIFO fills
    rdy_pct = 0;
    for (int i = 0; i < DEPTH; i++) write_byte(DW'(i));
    chk("burst_wr_ready", wr_ready, 0);
    rdy_pct = 100;
    repeat (120) step();
    chk("burst_rx_full", rx_level, DEPTH);
    chk("burst_tx_empty", tx_level, 0);
    chk("burst_head", rd_data, 8'hFF);

    // RX full stall
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (10) step();
    chk("stall_valid", m_tx_valid, 0);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("stall_next_head", rd_data, 8'hFE);
    chk("stall_valid_pop", m_tx_valid, 0);
    step();
    chk("stall_valid_rise", m_tx_valid, 1);
    rd_ready = 1'b1;
    repeat (60) step();
    rd_ready = 1'b0;

    // Flush while a byte is in flight
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    wait_in_flight(40);
    c0    = cnt;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_tx_level", tx_level, 0);
    chk("flush_rx_level", rx_level, 0);
    repeat (12) step();
    chk("flush_rx_after", rx_level, 0);
    chk("flush_cnt", xfer_count, c0 + 16'd1);
    chk("flush_idle", m_tx_valid, 0);

    // Continuous push with RX drained: full TX plus handshakes, many wraps
    rdy_pct  = 30;
    rd_ready = 1'b1;
    nb       = 8'h40;
    for (int i = 0; i < 300; i++) begin
      wr_valid = 1'b1;
      wr_data  = nb;
      if (wr_ready) nb = nb + 8'd1;
      step();
    end
    wr_valid = 1'b0;
    repeat (60) step();
    rd_ready = 1'b0;

    // Random traffic
    rdy_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = DW'($urandom);
      rd_ready = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 99) == 0);
      step();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    flush    = 1'b0;
    rdy_pct  = 100;
    repeat (20) step();

    // Asynchronous reset mid-transfer
    write_byte(8'h77);
    wait_in_flight(40);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("arst");
    model_reset();
    master_reset();
    step();
    rst_n = 1'b1;
    write_byte(8'h3C);
    repeat (15) step();
    chk("arst_rd", rd_data, 8'hC3);
    chk("arst_cnt", xfer_count, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
